// File: rtl/nota_pkg.sv
// nota_pkg: shared definitions for the note engine.
//   state_t       - player FSM encoding (IDLE -> LOAD -> PLAY)
//   CODE_SILENCE  - byte that silences the player and flushes the queue
//   bcd_inc       - one BCD digit increment, returns {carry, digit}
package nota_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2
    } state_t;

    localparam logic [7:0] CODE_SILENCE = 8'h30;

    function automatic logic [4:0] bcd_inc(input logic [3:0] digit, input logic cin);
        if (!cin)
            return {1'b0, digit};
        else if (digit == 4'd9)
            return {1'b1, 4'd0};
        else
            return {1'b0, digit + 4'd1};
    endfunction

endpackage

// File: rtl/nota_engine_if.sv
// nota_engine_if: byte input strobe, score control and player status.
//   master: drives rx_valid/rx_data/clear_score, observes status
//   slave : the engine side
interface nota_engine_if #(
    parameter int NUM_NOTES  = 3,
    parameter int NUM_DIGITS = 4
);
    logic                    rx_valid;
    logic [7:0]              rx_data;
    logic                    clear_score;
    logic [NUM_NOTES-1:0]    nota_activa;
    logic [4*NUM_DIGITS-1:0] score_bcd;
    logic                    fifo_full;
    logic                    overflow;
    logic                    bad_code;
    logic                    busy;

    modport master (
        output rx_valid, rx_data, clear_score,
        input  nota_activa, score_bcd, fifo_full, overflow, bad_code, busy
    );

    modport slave (
        input  rx_valid, rx_data, clear_score,
        output nota_activa, score_bcd, fifo_full, overflow, bad_code, busy
    );
endinterface

// File: rtl/nota_fifo.sv
// nota_fifo: synchronous FIFO with registered read data.
//   clk, rst_n : clock, async active-low reset
//   push/din   : write din when push (caller guarantees room or a same-cycle pop)
//   pop/dout   : dout holds the popped entry from the cycle after pop
//   flush      : zero both pointers, overrides push/pop
//   full/empty : occupancy flags
module nota_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // Extra MSB on each pointer separates full from empty.
    logic [AW:0]      wr_ptr, rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            dout   <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                // Push+pop while full: the read sees the old entry (NBA ordering).
                dout   <= mem[rd_ptr[AW-1:0]];
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
endmodule

// File: rtl/nota_engine.sv
// nota_engine: queues received note bytes and plays each as a one-hot note
// held for HOLD_CYCLES clocks, counting played notes in a BCD score.
//   clk, clr_n : clock, async active-low reset
//   bus.slave  : rx_valid/rx_data byte strobe, clear_score pulse in;
//                nota_activa, score_bcd, fifo_full, overflow, bad_code, busy out
module nota_engine
    import nota_pkg::*;
#(
    parameter int         NUM_NOTES   = 3,
    parameter int         HOLD_CYCLES = 5000000,
    parameter int         FIFO_DEPTH  = 4,
    parameter int         NUM_DIGITS  = 4,
    parameter logic [7:0] CODE_BASE   = 8'h31
) (
    input  logic          clk,
    input  logic          clr_n,
    nota_engine_if.slave  bus
);
    localparam int TW = $clog2(HOLD_CYCLES);

    state_t                     state_q, state_d;
    logic [TW-1:0]              timer_q;
    logic [NUM_NOTES-1:0]       nota_q;
    logic [NUM_DIGITS-1:0][3:0] score_q, score_nxt;
    logic                       ovf_q, bad_q;

    logic       silence, push, pop, drop, score_inc, code_ok;
    logic       fifo_full, fifo_empty;
    logic [7:0] hold_byte, note_idx;

    // Silence is never queued and preempts everything else this cycle.
    assign silence = bus.rx_valid && (bus.rx_data == CODE_SILENCE);
    assign push    = bus.rx_valid && !silence && (!fifo_full || pop);
    assign drop    = bus.rx_valid && !silence && fifo_full && !pop;

    // The FIFO's registered read port doubles as the holding register.
    nota_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (clr_n),
        .push  (push),
        .pop   (pop),
        .flush (silence),
        .din   (bus.rx_data),
        .dout  (hold_byte),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign code_ok  = (hold_byte >= CODE_BASE) &&
                      ({1'b0, hold_byte} < ({1'b0, CODE_BASE} + 9'(NUM_NOTES)));
    assign note_idx = hold_byte - CODE_BASE;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: if (!fifo_empty) begin
                pop     = 1'b1;
                state_d = ST_LOAD;
            end
            ST_LOAD: state_d = code_ok ? ST_PLAY : ST_IDLE;
            ST_PLAY: if (timer_q == '0) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (silence) begin
            pop     = 1'b0;
            state_d = ST_IDLE;
        end
    end

    assign score_inc = (state_q == ST_LOAD) && code_ok && !silence;

    // Decimal ripple: carry walks up through the digits; all-9s wraps to zero.
    always_comb begin
        logic       c;
        logic [4:0] r;
        c         = score_inc;
        r         = '0;
        score_nxt = score_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            r            = bcd_inc(score_q[i], c);
            score_nxt[i] = r[3:0];
            c            = r[4];
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            nota_q  <= '0;
            timer_q <= '0;
            score_q <= '0;
            ovf_q   <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            bad_q <= 1'b0;
            if (silence) begin
                nota_q  <= '0;
                timer_q <= '0;
            end else begin
                case (state_q)
                    ST_LOAD: if (code_ok) begin
                        nota_q  <= NUM_NOTES'(1) << note_idx;
                        timer_q <= TW'(HOLD_CYCLES - 1);
                    end else begin
                        bad_q   <= 1'b1;
                    end
                    ST_PLAY: if (timer_q == '0) nota_q <= '0;
                             else               timer_q <= timer_q - 1'b1;
                    default: ;
                endcase
            end

            if (bus.clear_score)  score_q <= '0;
            else if (score_inc)   score_q <= score_nxt;

            if (bus.clear_score)  ovf_q <= 1'b0;
            else if (drop)        ovf_q <= 1'b1;
        end
    end

    assign bus.nota_activa = nota_q;
    assign bus.score_bcd   = score_q;
    assign bus.fifo_full   = fifo_full;
    assign bus.overflow    = ovf_q;
    assign bus.bad_code    = bad_q;
    assign bus.busy        = (state_q != ST_IDLE) || !fifo_empty;
endmodule

// File: tb/tb_nota_engine.sv
// tb_nota_engine: directed stimulus for nota_engine with a queue-based
// reference model checked every cycle, plus hand-computed spot checks.
module tb_nota_engine;
    localparam int NN   = 3;
    localparam int HC   = 8;
    localparam int FD   = 4;
    localparam int ND   = 2;
    localparam int SMOD = 100;
    localparam int BASE = 8'h31;

    logic clk   = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    nota_engine_if #(.NUM_NOTES(NN), .NUM_DIGITS(ND)) bus();

    nota_engine #(
        .NUM_NOTES(NN), .HOLD_CYCLES(HC), .FIFO_DEPTH(FD),
        .NUM_DIGITS(ND), .CODE_BASE(8'h31)
    ) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    int vectors    = 0;
    int miscompares = 0;
    bit check_en   = 0;

    // Reference model: what has been accepted, what is about to sound,
    // and how many note cycles remain.
    int q[$];
    int pend  = -1;  // byte taken from the queue, decided on the next edge
    int left  = 0;   // remaining cycles of the current note
    int note  = 0;
    int score = 0;
    bit ovf   = 0;
    bit bad   = 0;

    task automatic model_reset();
        q.delete(); pend = -1; left = 0; note = 0; score = 0; ovf = 0; bad = 0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] d, input bit clr);
        bit idle, was_full, take;
        if (v && d == 8'h30) begin
            q.delete(); pend = -1; left = 0; bad = 0;
            if (clr) begin score = 0; ovf = 0; end
            return;
        end
        idle     = (pend < 0) && (left == 0);
        was_full = (q.size() == FD);
        take     = idle && (q.size() > 0);
        bad      = 0;
        if (pend >= 0) begin
            if (pend >= BASE && pend < BASE + NN) begin
                left  = HC;
                note  = pend - BASE;
                score = (score + 1) % SMOD;
            end else begin
                bad = 1;
            end
            pend = -1;
        end else if (left > 0) begin
            left--;
        end
        if (take) pend = q.pop_front();
        if (v) begin
            if (!was_full || take) q.push_back(int'(d));
            else                   ovf = 1;
        end
        if (clr) begin score = 0; ovf = 0; end
    endtask

    function automatic logic [NN-1:0] exp_nota();
        logic [NN-1:0] n;
        n = '0;
        if (left > 0) n[note] = 1'b1;
        return n;
    endfunction

    function automatic logic [4*ND-1:0] exp_score();
        return {4'(score / 10), 4'(score % 10)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("nota_activa", 32'(bus.nota_activa), 32'(exp_nota()));
            chk("score_bcd",   32'(bus.score_bcd),   32'(exp_score()));
            chk("fifo_full",   32'(bus.fifo_full),   32'(q.size() == FD));
            chk("overflow",    32'(bus.overflow),    32'(ovf));
            chk("bad_code",    32'(bus.bad_code),    32'(bad));
            chk("busy",        32'(bus.busy),        32'((pend >= 0) || (left > 0) || (q.size() > 0)));
        end
    end

    task automatic cyc(input bit v, input logic [7:0] d, input bit clr);
        bus.rx_valid    = v;
        bus.rx_data     = d;
        bus.clear_score = clr;
        @(posedge clk);
        if (clr_n) model_step(v, d, clr);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 8'h00, 1'b0);
    endtask

    task automatic all_zero(input string tag);
        chk({tag, ".nota"},  32'(bus.nota_activa), 0);
        chk({tag, ".score"}, 32'(bus.score_bcd),   0);
        chk({tag, ".full"},  32'(bus.fifo_full),   0);
        chk({tag, ".ovf"},   32'(bus.overflow),    0);
        chk({tag, ".bad"},   32'(bus.bad_code),    0);
        chk({tag, ".busy"},  32'(bus.busy),        0);
    endtask

    initial begin
        bus.rx_valid = 0; bus.rx_data = 0; bus.clear_score = 0;
        #12;
        all_zero("reset");
        @(negedge clk);
        clr_n = 1'b1;
        #1;
        model_reset();
        check_en = 1;

        // Single note 0x32: on from E2 for exactly 8 cycles.
        cyc(1'b1, 8'h32, 1'b0);
        idle(1);  chk("single.E1_silent", 32'(bus.nota_activa), 32'h0);
        idle(1);  chk("single.E2_on",     32'(bus.nota_activa), 32'h2);
                  chk("single.score",     32'(bus.score_bcd),   32'h01);
        idle(7);  chk("single.E9_on",     32'(bus.nota_activa), 32'h2);
        idle(1);  chk("single.E10_off",   32'(bus.nota_activa), 32'h0);
                  chk("single.busy_off",  32'(bus.busy),        32'h0);

        // Queue fill and overflow while the first note plays.
        cyc(1'b1, 8'h31, 1'b0);
        idle(2);
        repeat (6) cyc(1'b1, 8'h31, 1'b0);
        chk("queue.full", 32'(bus.fifo_full), 32'h1);
        chk("queue.ovf",  32'(bus.overflow),  32'h1);
        idle(60);
        chk("queue.score", 32'(bus.score_bcd), 32'h06);
        chk("queue.ovf_sticky", 32'(bus.overflow), 32'h1);

        // Clear score, then silence mid-note with one byte queued.
        cyc(1'b0, 8'h00, 1'b1);
        chk("clear.score", 32'(bus.score_bcd), 32'h00);
        chk("clear.ovf",   32'(bus.overflow),  32'h0);
        cyc(1'b1, 8'h33, 1'b0);
        idle(2);
        cyc(1'b1, 8'h31, 1'b0);
        idle(1);
        cyc(1'b1, 8'h30, 1'b0);
        chk("silence.nota",  32'(bus.nota_activa), 32'h0);
        chk("silence.busy",  32'(bus.busy),        32'h0);
        chk("silence.score", 32'(bus.score_bcd),   32'h01);
        idle(12);
        chk("silence.stays", 32'(bus.nota_activa), 32'h0);

        // Bad code pulses on E2 only.
        cyc(1'b1, 8'h41, 1'b0);
        idle(1);  chk("bad.E1", 32'(bus.bad_code), 32'h0);
        idle(1);  chk("bad.E2", 32'(bus.bad_code), 32'h1);
                  chk("bad.nota", 32'(bus.nota_activa), 32'h0);
        idle(1);  chk("bad.E3", 32'(bus.bad_code), 32'h0);
                  chk("bad.score", 32'(bus.score_bcd), 32'h01);

        // Score wrap 99 -> 00.
        repeat (98) begin
            cyc(1'b1, 8'h31, 1'b0);
            idle(10);
        end
        chk("wrap.99", 32'(bus.score_bcd), 32'h99);
        cyc(1'b1, 8'h32, 1'b0);
        idle(10);
        chk("wrap.00", 32'(bus.score_bcd), 32'h00);

        // clear_score coincident with the increment edge wins.
        cyc(1'b1, 8'h31, 1'b0);
        idle(10);
        chk("coinc.pre", 32'(bus.score_bcd), 32'h01);
        cyc(1'b1, 8'h33, 1'b0);
        idle(1);
        cyc(1'b0, 8'h00, 1'b1);
        chk("coinc.score", 32'(bus.score_bcd),   32'h00);
        chk("coinc.nota",  32'(bus.nota_activa), 32'h4);
        idle(9);

        // Reset mid-note with two bytes queued.
        cyc(1'b1, 8'h32, 1'b0);
        idle(2);
        cyc(1'b1, 8'h31, 1'b0);
        cyc(1'b1, 8'h33, 1'b0);
        idle(1);
        clr_n = 1'b0;
        #1;
        model_reset();
        all_zero("rst_mid");
        idle(3);
        clr_n = 1'b1;
        idle(20);
        chk("post_rst.nota", 32'(bus.nota_activa), 32'h0);
        chk("post_rst.busy", 32'(bus.busy),        32'h0);

        check_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
